// File: rtl/pixel_frame_pkg.sv
// rtl/pixel_frame_pkg.sv - shared state encoding, default parameters and sizing helper for the pixel frame controller
package pixel_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ERASE   = 3'd1,
    ST_EXPOSE  = 3'd2,
    ST_CONVERT = 3'd3,
    ST_READ    = 3'd4
  } frame_state_e;

  localparam int DEF_ARRAY_WIDTH    = 4;
  localparam int DEF_ARRAY_HEIGHT   = 4;
  localparam int DEF_ADC_BITS       = 8;
  localparam int DEF_ERASE_CYCLES   = 4;
  localparam int DEF_CONVERT_CYCLES = 256;
  localparam int DEF_EXP_W          = 16;

  // Counter holds (phase length - 1), so it needs clog2 of the longest phase.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pixel_phase_timer.sv
// rtl/pixel_phase_timer.sv - down-counting phase timer, loaded with length-1, done while at zero
module pixel_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load on phase entry, otherwise count down and park at zero (never wraps).
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/pixel_frame_ctrl.sv
// rtl/pixel_frame_ctrl.sv - erase/expose/convert/read frame sequencer with readout stream; PIXEL_FRAME_COUNT_EN adds frame_count
module pixel_frame_ctrl
  import pixel_frame_pkg::*;
#(
  parameter int ARRAY_WIDTH    = DEF_ARRAY_WIDTH,
  parameter int ARRAY_HEIGHT   = DEF_ARRAY_HEIGHT,
  parameter int ADC_BITS       = DEF_ADC_BITS,
  parameter int ERASE_CYCLES   = DEF_ERASE_CYCLES,
  parameter int CONVERT_CYCLES = DEF_CONVERT_CYCLES,
  parameter int EXP_W          = DEF_EXP_W,
  localparam int PIXEL_COUNT   = ARRAY_WIDTH * ARRAY_HEIGHT,
  localparam int SEL_W         = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1
) (
  input  logic                clk,
`ifdef PIXEL_FRAME_COUNT_EN
  output logic [15:0]         frame_count,
`endif
  input  logic                reset,
  input  logic                start,
  input  logic [EXP_W-1:0]    expose_time,
  output logic                busy,
  output logic                erase,
  output logic                expose,
  output logic                convert,
  output logic                read,
  output logic [SEL_W-1:0]    pixel_select,
  input  logic [ADC_BITS-1:0] pixel_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADC_BITS-1:0] out_data,
  output logic                out_last,
  output logic                frame_done
);

  localparam int CNT_W = cnt_width(ERASE_CYCLES, CONVERT_CYCLES, 2 ** EXP_W);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(PIXEL_COUNT - 1);

  frame_state_e     state_q, state_d;
  logic [EXP_W-1:0] expose_q;
  logic [SEL_W-1:0] pixel_select_q;
  logic             frame_done_q;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic [CNT_W-1:0] expose_load;
  logic             timer_done;
  logic             accept;
  logic             accept_last;

  pixel_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  // A zero exposure still spends one cycle in EXPOSE.
  assign expose_load = (expose_q == '0) ? '0 : (CNT_W'(expose_q) - CNT_W'(1));
  assign accept      = (state_q == ST_READ) && out_ready;
  assign accept_last = accept && (pixel_select_q == LAST_SEL);

  // State register; reset aborts any frame and wins over start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and timer load: each timed phase is loaded on the cycle it is entered.
  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_val  = '0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d    = ST_ERASE;
        timer_load = 1'b1;
        timer_val  = CNT_W'(ERASE_CYCLES - 1);
      end
      ST_ERASE: if (timer_done) begin
        state_d    = ST_EXPOSE;
        timer_load = 1'b1;
        timer_val  = expose_load;
      end
      ST_EXPOSE: if (timer_done) begin
        state_d    = ST_CONVERT;
        timer_load = 1'b1;
        timer_val  = CNT_W'(CONVERT_CYCLES - 1);
      end
      ST_CONVERT: if (timer_done) begin
        state_d = ST_READ;
      end
      ST_READ: if (accept_last) begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Phase strobes, busy and stream valid decoded from state.
  always_comb begin
    busy      = 1'b1;
    erase     = 1'b0;
    expose    = 1'b0;
    convert   = 1'b0;
    read      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_ERASE:   erase   = 1'b1;
      ST_EXPOSE:  expose  = 1'b1;
      ST_CONVERT: convert = 1'b1;
      ST_READ: begin
        read      = 1'b1;
        out_valid = 1'b1;
      end
      default:    busy    = 1'b0;
    endcase
  end

  // Exposure latch, pixel index walk and end-of-frame pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      expose_q       <= '0;
      pixel_select_q <= '0;
      frame_done_q   <= 1'b0;
    end else begin
      frame_done_q <= accept_last;
      if (state_q == ST_IDLE && start) begin
        expose_q <= expose_time;
      end
      if (accept) begin
        pixel_select_q <= accept_last ? '0 : (pixel_select_q + SEL_W'(1));
      end
    end
  end

`ifdef PIXEL_FRAME_COUNT_EN
  logic [15:0] frame_count_q;

  // Completed-frame counter, advances together with the frame_done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_q <= '0;
    end else if (accept_last) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign frame_count = frame_count_q;
`endif

  assign pixel_select = pixel_select_q;
  assign out_data     = pixel_data;
  assign out_last     = (state_q == ST_READ) && (pixel_select_q == LAST_SEL);
  assign frame_done   = frame_done_q;

endmodule

// File: doc/pixel_frame_ctrl.md
PIXEL_FRAME_CTRL -- requirements
Module: pixel_frame_ctrl

Interface
REQ-001 Parameter ARRAY_WIDTH, default 4, pixel columns (>=1).
REQ-002 Parameter ARRAY_HEIGHT, default 4, pixel rows (>=1); PIXEL_COUNT = ARRAY_WIDTH*ARRAY_HEIGHT.
REQ-003 Parameter ADC_BITS, default 8, pixel data width.
REQ-004 Parameter ERASE_CYCLES, default 4, erase phase length (>=1).
REQ-005 Parameter CONVERT_CYCLES, default 256, convert phase length (>=1).
REQ-006 Parameter EXP_W, default 16, exposure-time field width.
REQ-007 clk  in  1  single clock, all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  frame request, sampled only in IDLE.
REQ-010 expose_time  in  EXP_W  exposure length in cycles, latched on accepted start.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 erase, expose, convert, read  out  1 each  pixel array phase strobes.
REQ-013 pixel_select  out  $clog2(PIXEL_COUNT) (min 1)  linear pixel index, row-major.
REQ-014 pixel_data  in  ADC_BITS  array output for current pixel_select (combinational in the array).
REQ-015 out_valid / out_ready  out / in  1  readout stream handshake.
REQ-016 out_data  out  ADC_BITS  equals pixel_data while out_valid.
REQ-017 out_last  out  1  high with out_valid for pixel PIXEL_COUNT-1.
REQ-018 frame_done  out  1  one-cycle pulse after last pixel accepted.

Function
REQ-019 FSM states SHALL be IDLE, ERASE, EXPOSE, CONVERT, READ; exactly one phase strobe high per non-IDLE state, none in IDLE.
REQ-020 IDLE->ERASE on cycle after start=1 in IDLE; start in any other state SHALL be ignored (no queuing).
REQ-021 ERASE SHALL last ERASE_CYCLES cycles, then EXPOSE.
REQ-022 EXPOSE SHALL last max(latched expose_time,1) cycles (0 treated as 1), then CONVERT.
REQ-023 CONVERT SHALL last CONVERT_CYCLES cycles, then READ with pixel_select=0.
REQ-024 In READ, out_valid SHALL be 1; pixel_select SHALL increment by 1 on each cycle with out_valid&&out_ready, hold otherwise.
REQ-025 out_data/out_last SHALL be stable while out_valid&&!out_ready.
REQ-026 Acceptance with pixel_select==PIXEL_COUNT-1 SHALL go to IDLE next cycle, pulse frame_done that cycle, reset pixel_select to 0.
REQ-027 Single phase counter, width sized for max(ERASE_CYCLES,CONVERT_CYCLES,2^EXP_W); no wrap inside a phase.
REQ-028 Back-to-back: start held high SHALL begin next frame the cycle after returning to IDLE (one IDLE cycle minimum).

Reset
REQ-029 reset SHALL force IDLE; busy, strobes, out_valid, out_last, frame_done, pixel_select, counter, latched exposure all 0.
REQ-030 reset mid-frame (any state) SHALL abort the frame with no frame_done; takes priority over start.

Configuration
REQ-031 Macro PIXEL_FRAME_COUNT_EN defined: output frame_count [15:0], reset 0, increments on each frame_done, wraps 0xFFFF->0.
REQ-032 Macro undefined: no frame_count port or counter logic; all other behaviour identical.

Structure
REQ-033 Package pixel_frame_pkg SHALL hold the FSM state enum and a default-parameter constants set.
REQ-034 One sub-module pixel_phase_timer (load/count/done) is natural; FSM and stream logic stay in pixel_frame_ctrl.

Verification
REQ-035 Defaults, expose_time=10, start pulse, out_ready=1 -> erase 4, expose 10, convert 256 cycles; 16 beats, select 0..15, out_last on 16th, frame_done 1 cycle later, busy low.
REQ-036 out_ready toggling 1/0 each cycle -> 16 accepted beats over 32 cycles, out_data/select held on stall cycles.
REQ-037 expose_time=0 -> expose high exactly 1 cycle; start during CONVERT -> ignored, one frame only.
REQ-038 reset asserted in 3rd CONVERT cycle -> next cycle IDLE, all outputs 0, no frame_done; new start runs full frame.
REQ-039 ARRAY_WIDTH=3, ARRAY_HEIGHT=1 -> 3 beats, select width 2, out_last at select 2.
REQ-040 PIXEL_FRAME_COUNT_EN defined, 3 frames back-to-back with start held -> frame_count 1,2,3; single IDLE cycle between frames.
